// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop input sync, mid-bit start validation,
// LSB-first data sampling at bit centres, stop-bit check, and a
// ready/read handshake with sticky overrun and framing-error flags.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       i_Clk_12MHz,
    input  logic       i_Reset_n,
    input  logic       i_Rx,
    input  logic       i_Rd_En,
    output logic [7:0] o_Data_Out,
    output logic       o_Rx_Ready,
    output logic       o_Overrun,
    output logic       o_Frame_Err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;     // synchronised line; every decision uses this
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             ready_q, ready_d;
    logic             ovr_q, ovr_d;
    logic             fe_q, fe_d;

    // State register and all datapath flops; reset abandons any frame in flight.
    always_ff @(posedge i_Clk_12MHz) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!i_Reset_n) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            rx_s_q    <= rx_s_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            fe_q      <= fe_d;
        end
    end

    // Next-state, bit timing, shifting and handshake flag logic.
    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d   = state_q;
        sync1_d   = i_Rx;
        rx_s_d    = sync1_q;
        cnt_d     = '0;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = ready_q;
        ovr_d     = ovr_q;
        fe_d      = fe_q;

        // A read clears the flags; a same-cycle load or frame error below overrides.
        if (i_Rd_En) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
            fe_d    = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;   // too short to be a start bit
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        if (ready_q && !i_Rd_En) ovr_d = 1'b1;
                        state_d = S_IDLE;   // re-armed at mid-stop for back-to-back frames
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                // Wait for the line to return high so a held-low line is not decoded as 8'h00s.
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_Data_Out  = data_q;
    assign o_Rx_Ready  = ready_q;
    assign o_Overrun   = ovr_q;
    assign o_Frame_Err = fe_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized
// frames compared against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int CPB = 40;     // short bit period keeps the run small

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       ready, ovr, fe;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Frame-level reference model of the visible outputs.
    logic [7:0] m_data;
    logic       m_ready, m_ovr, m_fe;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk_12MHz (clk),
        .i_Reset_n   (rst_n),
        .i_Rx        (rx),
        .i_Rd_En     (rd),
        .o_Data_Out  (data),
        .o_Rx_Ready  (ready),
        .o_Overrun   (ovr),
        .o_Frame_Err (fe)
    );

    always #41.667 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    endfunction

    function automatic void model_read();
        m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    endfunction

    // A completed frame with no read in flight: good frames load, bad ones flag.
    function automatic void model_frame(input logic [7:0] b, input logic good);
        if (good) begin
            if (m_ready) m_ovr = 1'b1;
            m_data  = b;
            m_ready = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
    endfunction

    task automatic check_model(input string tag);
        check({tag, " data"},  32'(data),  32'(m_data));
        check({tag, " ready"}, 32'(ready), 32'(m_ready));
        check({tag, " ovr"},   32'(ovr),   32'(m_ovr));
        check({tag, " fe"},    32'(fe),    32'(m_fe));
    endtask

    task automatic idle_line(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first, and the given stop bit; rx left at stop level.
    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_bit);
        rx = 1'b0;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (cpb) @(negedge clk);
        end
        rx = stop_bit;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic read_pulse();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        model_read();
    endtask

    initial begin
        int lat;
        int lat_exp;
        int base;
        logic [7:0] b;
        logic good;
        int cpb;

        model_reset();
        repeat (3) @(negedge clk);
        check_model("reset");
        rst_n = 1'b1;
        idle_line(20);

        // Nominal byte with latency measured from the start edge.
        lat = 0;
        lat_exp = (19 * CPB) / 2;
        fork
            send_frame(8'hA5, CPB, 1'b1);
            begin
                while (!ready && lat < 2000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        idle_line(20);
        check("latency_window", 32'(lat >= lat_exp - 4 && lat <= lat_exp + 4), 32'd1);
        model_frame(8'hA5, 1'b1);
        check_model("nominal");
        read_pulse();
        check_model("nominal_read");
        read_pulse();
        check_model("read_when_empty");

        // Glitch shorter than half a bit is ignored; next frame still decodes.
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        idle_line(3 * CPB);
        check_model("glitch");
        send_frame(8'h3C, CPB, 1'b1);
        idle_line(20);
        model_frame(8'h3C, 1'b1);
        check_model("after_glitch");
        read_pulse();

        // Framing error followed by a 5 bit-time break: one flag, no 8'h00 bytes.
        send_frame(8'h55, CPB, 1'b0);
        rx = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        idle_line(3 * CPB);
        model_frame(8'h55, 1'b0);
        check_model("frame_err_break");
        read_pulse();
        check_model("frame_err_cleared");
        send_frame(8'h12, CPB, 1'b1);
        idle_line(20);
        model_frame(8'h12, 1'b1);
        check_model("after_break");
        read_pulse();

        // Back-to-back 01,02,03: overrun on 02, read coincident with the 03 load.
        fork
            begin
                send_frame(8'h01, CPB, 1'b1);
                send_frame(8'h02, CPB, 1'b1);
                send_frame(8'h03, CPB, 1'b1);
                rx = 1'b1;
            end
            begin
                lat = 0;
                while (!ready && lat < 2000) begin
                    @(negedge clk);
                    lat++;
                end
                check("b2b_first_ready", 32'(ready), 32'd1);
                base = cyc;
                while (cyc < base + 10 * CPB) @(negedge clk);
                check("b2b_data_02", 32'(data), 32'h02);
                check("b2b_overrun", 32'(ovr), 32'd1);
                while (cyc < base + 20 * CPB - 1) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
                check("load_wins_data", 32'(data), 32'h03);
                check("load_wins_ready", 32'(ready), 32'd1);
                check("load_wins_ovr", 32'(ovr), 32'd0);
            end
        join
        idle_line(20);
        m_data = 8'h03; m_ready = 1'b1; m_ovr = 1'b0; m_fe = 1'b0;
        check_model("b2b_end");
        read_pulse();

        // Reset held two clocks in the middle of data bit 4 of 8'hFF.
        fork
            send_frame(8'hFF, CPB, 1'b1);
            begin
                repeat (5 * CPB + CPB / 2) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                model_reset();
                check_model("reset_mid_frame");
            end
        join
        idle_line(3 * CPB);
        check_model("reset_no_ready");
        send_frame(8'h81, CPB, 1'b1);
        idle_line(20);
        model_frame(8'h81, 1'b1);
        check_model("after_reset");
        read_pulse();

        // Baud tolerance at both ends of the window.
        send_frame(8'hC3, CPB - 1, 1'b1);
        idle_line(20);
        model_frame(8'hC3, 1'b1);
        check_model("baud_fast");
        read_pulse();
        send_frame(8'hC3, CPB + 1, 1'b1);
        idle_line(20);
        model_frame(8'hC3, 1'b1);
        check_model("baud_slow");
        read_pulse();

        // Randomized frames: byte, stop validity, bit period and read all vary.
        for (int i = 0; i < 12; i++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            cpb  = $urandom_range(CPB - 1, CPB + 1);
            send_frame(b, cpb, good);
            idle_line(2 * CPB);
            model_frame(b, good);
            check_model("random");
            if ($urandom_range(0, 1) == 1) read_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Receive side of the team's 8N1 UART, clocked from the 12 MHz system clock with no derived clocks. It synchronises i_Rx and validates the start bit at mid-bit. It samples 8 data bits LSB-first at bit centres, checks the stop bit, and presents the byte behind a ready/read handshake with sticky overrun and framing-error flags. It sits beside the transmitter and shares its line format and 9600 baud default.

Parameters:
CLKS_PER_BIT, 1250, system clocks per UART bit (12 MHz / 9600); must be at least 8.
HALF_BIT, CLKS_PER_BIT/2 (625), clocks from start-edge detection to the start-bit centre sample.

Ports:
i_Clk_12MHz  input  1  system clock; all logic on its rising edge.
i_Reset_n  input  1  synchronous active-low reset.
i_Rx  input  1  asynchronous serial line; idles high.
i_Rd_En  input  1  consumer acknowledge; clears o_Rx_Ready, o_Overrun and o_Frame_Err.
o_Data_Out  output  8  last good received byte; holds until the next good byte.
o_Rx_Ready  output  1  high while o_Data_Out holds an unread byte.
o_Overrun  output  1  sticky: a good byte arrived while o_Rx_Ready was high and unacknowledged.
o_Frame_Err  output  1  sticky: stop bit was sampled low.

Behaviour:
- Reset (i_Reset_n low at a clock edge) gives: state IDLE, both sync flops = 1, counters = 0, shift register = 0, o_Data_Out = 8'h00, o_Rx_Ready = 0, o_Overrun = 0, o_Frame_Err = 0. Reset mid-frame abandons the frame with no flag set.
- Input sync: i_Rx passes through 2 flops. All decisions use the second flop, rx_s.
- Bit counter counts 0..N-1 in each timed state and resets to 0 on every state change.
- IDLE: if rx_s == 0, go to START.
- START: on count HALF_BIT-1, sample rx_s.
  - rx_s == 0: go to DATA, bit index = 0.
  - rx_s == 1: treat as a glitch and return to IDLE. No flag, no output change.
- DATA: on count CLKS_PER_BIT-1, shift rx_s into the shift register (LSB first) and increment the bit index. After bit index 7 is sampled, go to STOP.
- STOP: on count CLKS_PER_BIT-1, sample rx_s.
  - rx_s == 1 (good byte): o_Data_Out <= shift register; o_Rx_Ready <= 1. If o_Rx_Ready was already 1 and i_Rd_En is low this cycle, o_Overrun <= 1. Go to IDLE.
  - rx_s == 0 (framing error): byte discarded; o_Data_Out and o_Rx_Ready unchanged; o_Frame_Err <= 1. Go to BREAK.
- BREAK: stay until rx_s == 1, then go to IDLE. This prevents a held-low line (break) from being decoded as repeated 8'h00 frames.
- i_Rd_En clears o_Rx_Ready, o_Overrun and o_Frame_Err on the next edge. i_Rd_En while o_Rx_Ready == 0 is harmless. o_Data_Out is never cleared by a read.
- Simultaneous i_Rd_En and good-byte load: the load wins. o_Rx_Ready stays 1 with the new byte, o_Overrun is not set, and any prior o_Overrun is cleared.
- Simultaneous i_Rd_En and framing error: o_Frame_Err ends at 1; o_Rx_Ready is cleared.
- Latency: o_Rx_Ready rises 9.5 bit-times (11875 clocks at defaults) after the i_Rx falling edge, ±4 clocks for sync/FSM overhead.
- Back-to-back frames are received with no idle gap: IDLE is re-entered at mid-stop, so the next start edge is caught.
- State encoding: 3 bits (IDLE, START, DATA, STOP, BREAK). Unused codes return to IDLE.

Test Plan:
- Nominal byte: drive 8'hA5 at 1250 clk/bit (start, 1,0,1,0,0,1,0,1, stop) -> o_Data_Out == 8'hA5 and o_Rx_Ready rises at 11875±4 clocks; o_Frame_Err == 0, o_Overrun == 0; i_Rd_En pulse -> o_Rx_Ready == 0 next edge, o_Data_Out still 8'hA5.
- Glitch rejection: low pulse of 300 clocks on an idle line -> state returns to IDLE; no o_Rx_Ready, no flags. A following 8'h3C frame is received correctly.
- Framing error and break: send 8'h55 with stop bit low, then hold i_Rx low for 5 bit-times -> o_Frame_Err == 1, o_Rx_Ready stays 0, no spurious 8'h00 bytes. Release the line, send 8'h12 -> o_Data_Out == 8'h12.
- Overrun: send 8'h01 then 8'h02 back-to-back without i_Rd_En -> o_Data_Out == 8'h02, o_Overrun == 1. Repeat with i_Rd_En asserted on the exact load cycle of 8'h02 -> o_Overrun == 0, o_Rx_Ready == 1.
- Reset mid-frame: assert i_Reset_n low for 2 clocks during data bit 4 of 8'hFF -> all outputs at reset values; the remainder of that frame does not produce o_Rx_Ready. The next 8'h81 frame is received.
- Baud tolerance: send 8'hC3 at 1225 and at 1275 clk/bit (±2%) -> o_Data_Out == 8'hC3, no flags.
